sound_mailbox_ctrl: RTL and testbench

SOUND_MAILBOX_CTRL -- requirements
Module: sound_mailbox_ctrl

---
 rtl/sound_mailbox_ctrl.sv | 141 ++++++++++++++
 tb/tb_sound_mailbox_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sound_mailbox_ctrl.sv
// 68K <-> Z80 sound mailbox: 4-entry command FIFO with NMI notification and
// timeout re-notify, plus a single-byte reply register.
module sound_mailbox_ctrl #(
    parameter int          NMI_WIDTH   = 8,
    parameter logic [15:0] TIMEOUT_CYC = 16'd49152
) (
    input  logic       CLK_24M,
    input  logic       nRESET,
    input  logic       CMD_WR,
    input  logic [7:0] CMD_DATA,
    input  logic       REP_RD,
    output logic [7:0] REP_DATA,
    input  logic       Z80_CMD_RD,
    output logic [7:0] Z80_CMD_DATA,
    input  logic       Z80_REP_WR,
    input  logic [7:0] Z80_REP_DATA,
    input  logic       Z80_CLR,
    output logic       nZ80NMI,
    output logic       CMD_FULL,
    output logic       CMD_OVF,
    output logic       REP_VALID,
    output logic       TIMEOUT
);

    localparam int NCW = $clog2(NMI_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, NMI, WAIT_RD} state_t;

    state_t         state, state_next;
    logic [NCW-1:0] nmi_cnt, nmi_cnt_next;
    logic [15:0]    tmo_cnt, tmo_cnt_next;
    logic           timeout_hit;

    logic [7:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic       push, pop, drop;

    // A pop frees a slot in the same cycle, so a full queue still accepts a push.
    assign pop  = Z80_CMD_RD && (count != 3'd0) && !Z80_CLR;
    assign push = CMD_WR && !Z80_CLR && ((count != 3'd4) || pop);
    assign drop = CMD_WR && !Z80_CLR && (count == 3'd4) && !pop;

    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else if (Z80_CLR) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(push) - 3'(pop);
        end
    end

    // NOTE: storage is not reset; the empty-queue mux hides stale contents.
    always_ff @(posedge CLK_24M) begin
        if (push) mem[wr_ptr] <= CMD_DATA;
    end

    assign Z80_CMD_DATA = (count != 3'd0) ? mem[rd_ptr] : 8'h00;
    assign CMD_FULL     = (count == 3'd4);
    assign nZ80NMI      = (state != NMI);

    // NOTE: next-state logic assigns every output a default first so no latch is inferred.
    always_comb begin
        state_next   = state;
        nmi_cnt_next = nmi_cnt;
        tmo_cnt_next = tmo_cnt;
        timeout_hit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != 3'd0 && !pop) begin
                    state_next   = NMI;
                    nmi_cnt_next = NCW'(NMI_WIDTH);
                end
            end
            NMI: begin
                if (pop) begin
                    state_next = IDLE;
                end else if (nmi_cnt == NCW'(1)) begin
                    state_next   = WAIT_RD;
                    tmo_cnt_next = 16'd0;
                end else begin
                    nmi_cnt_next = nmi_cnt - NCW'(1);
                end
            end
            WAIT_RD: begin
                if (pop) begin
                    state_next = IDLE;
                end else if (tmo_cnt == TIMEOUT_CYC - 16'd1) begin
                    state_next   = NMI;
                    nmi_cnt_next = NCW'(NMI_WIDTH);
                    timeout_hit  = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (Z80_CLR) begin
            state_next  = IDLE;
            timeout_hit = 1'b0;
        end
    end

    // NOTE: all sequential state uses non-blocking assignment.
    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            state   <= IDLE;
            nmi_cnt <= '0;
            tmo_cnt <= 16'd0;
            CMD_OVF <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            state   <= state_next;
            nmi_cnt <= nmi_cnt_next;
            tmo_cnt <= tmo_cnt_next;
            if (drop)        CMD_OVF <= 1'b1;
            if (timeout_hit) TIMEOUT <= 1'b1;
        end
    end

    // A same-cycle Z80 write beats the 68K read-clear.
    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            REP_DATA  <= 8'h00;
            REP_VALID <= 1'b0;
        end else if (Z80_REP_WR) begin
            REP_DATA  <= Z80_REP_DATA;
            REP_VALID <= 1'b1;
        end else if (REP_RD) begin
            REP_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sound_mailbox_ctrl.sv
// Directed bench for sound_mailbox_ctrl: reset, notify/read, overflow,
// timeout re-notify, full push+pop, reply handshake, clear and mid-NMI reset.
module tb_sound_mailbox_ctrl;

    localparam int          NMI_W = 8;
    localparam logic [15:0] TMO   = 16'd20;

    logic       clk = 1'b0;
    logic       nreset;
    logic       cmd_wr;
    logic [7:0] cmd_data;
    logic       rep_rd;
    logic [7:0] rep_data;
    logic       z80_cmd_rd;
    logic [7:0] z80_cmd_data;
    logic       z80_rep_wr;
    logic [7:0] z80_rep_data;
    logic       z80_clr;
    logic       nmi_n;
    logic       cmd_full;
    logic       cmd_ovf;
    logic       rep_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sound_mailbox_ctrl #(.NMI_WIDTH(NMI_W), .TIMEOUT_CYC(TMO)) dut (
        .CLK_24M      (clk),
        .nRESET       (nreset),
        .CMD_WR       (cmd_wr),
        .CMD_DATA     (cmd_data),
        .REP_RD       (rep_rd),
        .REP_DATA     (rep_data),
        .Z80_CMD_RD   (z80_cmd_rd),
        .Z80_CMD_DATA (z80_cmd_data),
        .Z80_REP_WR   (z80_rep_wr),
        .Z80_REP_DATA (z80_rep_data),
        .Z80_CLR      (z80_clr),
        .nZ80NMI      (nmi_n),
        .CMD_FULL     (cmd_full),
        .CMD_OVF      (cmd_ovf),
        .REP_VALID    (rep_valid),
        .TIMEOUT      (timeout)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs settle and outputs are sampled 1ns after it.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cmd_wr     = 1'b0;
            rep_rd     = 1'b0;
            z80_cmd_rd = 1'b0;
            z80_rep_wr = 1'b0;
            z80_clr    = 1'b0;
        end
    endtask

    task automatic write_cmd(input logic [7:0] d);
        cmd_wr   = 1'b1;
        cmd_data = d;
        tick();
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        tick(2);
        nreset = 1'b1;
    endtask

    initial begin
        nreset = 1'b0; cmd_wr = 1'b0; cmd_data = 8'h00; rep_rd = 1'b0;
        z80_cmd_rd = 1'b0; z80_rep_wr = 1'b0; z80_rep_data = 8'h00; z80_clr = 1'b0;
        #1;
        do_reset();

        check("rst_nmi",      {7'd0, nmi_n},     8'h01);
        check("rst_full",     {7'd0, cmd_full},  8'h00);
        check("rst_ovf",      {7'd0, cmd_ovf},   8'h00);
        check("rst_timeout",  {7'd0, timeout},   8'h00);
        check("rst_repvalid", {7'd0, rep_valid}, 8'h00);
        check("rst_repdata",  rep_data,          8'h00);
        check("rst_cmddata",  z80_cmd_data,      8'h00);

        // Single command: data next cycle, NMI low for NMI_W cycles one cycle later.
        write_cmd(8'h07);
        check("t1_data", z80_cmd_data, 8'h07);
        check("t1_nmi_idle", {7'd0, nmi_n}, 8'h01);
        tick();
        for (int i = 0; i < NMI_W; i++) begin
            check($sformatf("t1_nmi_low%0d", i), {7'd0, nmi_n}, 8'h00);
            tick();
        end
        check("t1_nmi_end", {7'd0, nmi_n}, 8'h01);
        z80_cmd_rd = 1'b1;
        tick();
        check("t1_empty", z80_cmd_data, 8'h00);
        tick(3);
        check("t1_idle_nmi", {7'd0, nmi_n}, 8'h01);
        check("t1_no_timeout", {7'd0, timeout}, 8'h00);

        // Read on an empty queue does nothing.
        z80_cmd_rd = 1'b1;
        tick();
        check("empty_rd_data", z80_cmd_data, 8'h00);
        check("empty_rd_nmi", {7'd0, nmi_n}, 8'h01);

        // Five writes overflow a four-deep queue; FIFO order preserved.
        for (int i = 1; i <= 5; i++) write_cmd(8'(i));
        check("t2_full", {7'd0, cmd_full}, 8'h01);
        check("t2_ovf",  {7'd0, cmd_ovf},  8'h01);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t2_head%0d", i), z80_cmd_data, 8'(i));
            z80_cmd_rd = 1'b1;
            tick();
        end
        check("t2_empty", z80_cmd_data, 8'h00);
        check("t2_not_full", {7'd0, cmd_full}, 8'h00);
        check("t2_ovf_sticky", {7'd0, cmd_ovf}, 8'h01);
        tick(2);

        // No read for TMO cycles -> TIMEOUT and a second NMI pulse, same byte.
        write_cmd(8'h3C);
        tick();
        check("t3_nmi1", {7'd0, nmi_n}, 8'h00);
        tick(NMI_W);
        check("t3_wait", {7'd0, nmi_n}, 8'h01);
        tick(int'(TMO) - 1);
        check("t3_wait_last", {7'd0, nmi_n}, 8'h01);
        check("t3_tmo_before", {7'd0, timeout}, 8'h00);
        tick();
        check("t3_tmo", {7'd0, timeout}, 8'h01);
        check("t3_same_byte", z80_cmd_data, 8'h3C);
        for (int i = 0; i < NMI_W; i++) begin
            check($sformatf("t3_nmi2_low%0d", i), {7'd0, nmi_n}, 8'h00);
            tick();
        end
        check("t3_nmi2_end", {7'd0, nmi_n}, 8'h01);
        z80_cmd_rd = 1'b1;
        tick();
        check("t3_popped", z80_cmd_data, 8'h00);
        check("t3_tmo_sticky", {7'd0, timeout}, 8'h01);

        // Full queue with same-cycle push and pop.
        do_reset();
        write_cmd(8'h11); write_cmd(8'h22); write_cmd(8'h33); write_cmd(8'h44);
        check("t4_full", {7'd0, cmd_full}, 8'h01);
        cmd_wr = 1'b1; cmd_data = 8'hAA; z80_cmd_rd = 1'b1;
        tick();
        check("t4_still_full", {7'd0, cmd_full}, 8'h01);
        check("t4_no_ovf", {7'd0, cmd_ovf}, 8'h00);
        check("t4_head22", z80_cmd_data, 8'h22);
        z80_cmd_rd = 1'b1; tick();
        check("t4_head33", z80_cmd_data, 8'h33);
        z80_cmd_rd = 1'b1; tick();
        check("t4_head44", z80_cmd_data, 8'h44);
        z80_cmd_rd = 1'b1; tick();
        check("t4_headAA", z80_cmd_data, 8'hAA);
        z80_cmd_rd = 1'b1; tick();
        check("t4_empty", z80_cmd_data, 8'h00);

        // Reply register: write beats same-cycle read, lone read clears.
        check("t5_valid0", {7'd0, rep_valid}, 8'h00);
        z80_rep_wr = 1'b1; z80_rep_data = 8'h5C; rep_rd = 1'b1;
        tick();
        check("t5_valid", {7'd0, rep_valid}, 8'h01);
        check("t5_data", rep_data, 8'h5C);
        tick();
        check("t5_valid_hold", {7'd0, rep_valid}, 8'h01);
        rep_rd = 1'b1;
        tick();
        check("t5_cleared", {7'd0, rep_valid}, 8'h00);
        check("t5_data_kept", rep_data, 8'h5C);

        // Clear flushes and beats a same-cycle write on a full queue.
        write_cmd(8'h01); write_cmd(8'h02); write_cmd(8'h03); write_cmd(8'h04);
        cmd_wr = 1'b1; cmd_data = 8'hEE; z80_clr = 1'b1;
        tick();
        check("clr_empty", z80_cmd_data, 8'h00);
        check("clr_not_full", {7'd0, cmd_full}, 8'h00);
        check("clr_no_ovf", {7'd0, cmd_ovf}, 8'h00);
        check("clr_nmi", {7'd0, nmi_n}, 8'h01);
        tick(2);
        check("clr_stays_idle", {7'd0, nmi_n}, 8'h01);

        // Reset in the middle of an NMI pulse with three entries queued.
        z80_rep_wr = 1'b1; z80_rep_data = 8'h9A; tick();
        write_cmd(8'hA1); write_cmd(8'hA2); write_cmd(8'hA3);
        check("t6_in_nmi", {7'd0, nmi_n}, 8'h00);
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        check("t6_nmi", {7'd0, nmi_n}, 8'h01);
        check("t6_empty", z80_cmd_data, 8'h00);
        check("t6_full", {7'd0, cmd_full}, 8'h00);
        check("t6_ovf", {7'd0, cmd_ovf}, 8'h00);
        check("t6_timeout", {7'd0, timeout}, 8'h00);
        check("t6_repvalid", {7'd0, rep_valid}, 8'h00);
        check("t6_repdata", rep_data, 8'h00);
        tick(2);
        check("t6_stays_idle", {7'd0, nmi_n}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
